// File: rtl/gray_expand_pipe.sv
// gray_expand_pipe: a two-stage video pipeline. It maps each gray sample
// through a per-frame mode and expands the result into NUM_CH identical
// colour channels. It also measures the active length of each line.
//
// Handshake: there is no backpressure. A pixel is accepted on every clock
// edge where vid_in_active=1. It leaves exactly two edges later, with
// vid_out_active=1, together with its delayed hsync and vsync.
module gray_expand_pipe #(
    parameter int GRAY_W = 8,
    parameter int CH_W   = 8,
    parameter int NUM_CH = 3,
    parameter int CNT_W  = 12
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     vid_in_active,
    input  logic [GRAY_W-1:0]        vid_in_data,
    input  logic                     vid_in_hsync,
    input  logic                     vid_in_vsync,
    input  logic [1:0]               mode_in,
    input  logic [GRAY_W-1:0]        thresh_in,
    output logic                     vid_out_active,
    output logic                     vid_out_hsync,
    output logic                     vid_out_vsync,
    output logic [NUM_CH*CH_W-1:0]   vid_out_data,
    output logic [1:0]               mode_cur,
    output logic [CNT_W-1:0]         line_len,
    output logic                     line_len_vld
);

    typedef enum logic [1:0] {
        MODE_REPL   = 2'd0,
        MODE_INV    = 2'd1,
        MODE_THRESH = 2'd2,
        MODE_ZERO   = 2'd3
    } mode_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Frame-level state: the previous syncs, and the mode/threshold latched at frame start
    logic                  prev_vs_q;
    logic                  prev_act_q;
    mode_t                 mode_q,   mode_d;
    logic [GRAY_W-1:0]     thresh_q, thresh_d;

    // Stage 1: the mapped gray value and its syncs
    logic                  s1_act_q, s1_hs_q, s1_vs_q;
    logic [GRAY_W-1:0]     s1_p_q,   s1_p_d;

    // Stage 2: the expanded output
    logic                  out_act_q, out_hs_q, out_vs_q;
    logic [NUM_CH*CH_W-1:0] out_data_q, out_data_d;

    // Line-length measurement
    logic [CNT_W-1:0]      cnt_q,      cnt_d;
    logic [CNT_W-1:0]      line_len_q, line_len_d;
    logic                  vld_q,      vld_d;

    logic                  vs_rise;
    logic                  act_fall;
    logic [CH_W-1:0]       ch_val;

    // Widen the stage-1 value to one channel by repeating its top bits
    generate
        if (CH_W == GRAY_W) begin : g_no_expand
            assign ch_val = s1_p_q;
        end else begin : g_expand
            assign ch_val = {s1_p_q, s1_p_q[GRAY_W-1 -: CH_W-GRAY_W]};
        end
    endgenerate

    // Next-state logic. A mode loaded on a vsync edge applies to the pixel of that same cycle.
    always_comb begin
        vs_rise  = vid_in_vsync & ~prev_vs_q;
        act_fall = ~vid_in_active & prev_act_q;

        mode_d   = mode_q;
        thresh_d = thresh_q;
        if (vs_rise) begin
            mode_d   = mode_t'(mode_in);
            thresh_d = thresh_in;
        end

        s1_p_d = '0;
        case (mode_d)
            MODE_REPL:   s1_p_d = vid_in_data;
            MODE_INV:    s1_p_d = ~vid_in_data;
            MODE_THRESH: s1_p_d = (vid_in_data >= thresh_d) ? {GRAY_W{1'b1}} : '0;
            MODE_ZERO:   s1_p_d = '0;
            default:     s1_p_d = '0;
        endcase

        out_data_d = s1_act_q ? {NUM_CH{ch_val}} : '0;

        // A line end captures the count. Both a line end and a frame start restart the count.
        line_len_d = line_len_q;
        vld_d      = 1'b0;
        if (act_fall) begin
            line_len_d = cnt_q;
            vld_d      = 1'b1;
        end

        cnt_d = cnt_q;
        if (act_fall || vs_rise) begin
            cnt_d = '0;
        end else if (vid_in_active && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    // Register every stage. Reset also clears the history, so a mid-line reset never produces a strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_vs_q  <= 1'b0;
            prev_act_q <= 1'b0;
            mode_q     <= MODE_REPL;
            thresh_q   <= '0;
            s1_act_q   <= 1'b0;
            s1_hs_q    <= 1'b0;
            s1_vs_q    <= 1'b0;
            s1_p_q     <= '0;
            out_act_q  <= 1'b0;
            out_hs_q   <= 1'b0;
            out_vs_q   <= 1'b0;
            out_data_q <= '0;
            cnt_q      <= '0;
            line_len_q <= '0;
            vld_q      <= 1'b0;
        end else begin
            prev_vs_q  <= vid_in_vsync;
            prev_act_q <= vid_in_active;
            mode_q     <= mode_d;
            thresh_q   <= thresh_d;
            s1_act_q   <= vid_in_active;
            s1_hs_q    <= vid_in_hsync;
            s1_vs_q    <= vid_in_vsync;
            s1_p_q     <= s1_p_d;
            out_act_q  <= s1_act_q;
            out_hs_q   <= s1_hs_q;
            out_vs_q   <= s1_vs_q;
            out_data_q <= out_data_d;
            cnt_q      <= cnt_d;
            line_len_q <= line_len_d;
            vld_q      <= vld_d;
        end
    end

    assign vid_out_active = out_act_q;
    assign vid_out_hsync  = out_hs_q;
    assign vid_out_vsync  = out_vs_q;
    assign vid_out_data   = out_data_q;
    assign mode_cur       = mode_q;
    assign line_len       = line_len_q;
    assign line_len_vld   = vld_q;

endmodule

// File: doc/gray_expand_pipe.md
GRAY_EXPAND_PIPE -- requirements
Module: gray_expand_pipe

Interface
REQ-001 Parameter GRAY_W, default 8: input gray sample width; legal range 4..16.
REQ-002 Parameter CH_W, default 8: output width per channel; legal range GRAY_W..2*GRAY_W.
REQ-003 Parameter NUM_CH, default 3: output channel count; legal range 1..4.
REQ-004 Parameter CNT_W, default 12: width of the line-length counter.
REQ-005 clk  in  1  sole clock; all logic rises on posedge clk.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 vid_in_active  in  1  input pixel-valid.
REQ-008 vid_in_data  in  GRAY_W  gray sample.
REQ-009 vid_in_hsync, vid_in_vsync  in  1 each  input syncs, active-high.
REQ-010 mode_in  in  2  requested mode: 0 replicate, 1 invert, 2 threshold, 3 bypass-zero.
REQ-011 thresh_in  in  GRAY_W  threshold for mode 2.
REQ-012 vid_out_active, vid_out_hsync, vid_out_vsync  out  1 each  delayed syncs/valid.
REQ-013 vid_out_data  out  NUM_CH*CH_W  channel 0 in the MSBs; every channel carries an identical value.
REQ-014 mode_cur  out  2  mode currently applied.
REQ-015 line_len  out  CNT_W  active-pixel count of the last completed line.
REQ-016 line_len_vld  out  1  one-cycle strobe when line_len updates.

Function
REQ-017 Latency is exactly 2 clk from input to output for active, hsync, vsync and data; all are registered through the same 2-stage pipeline.
REQ-018 Stage 1 computes the gray value p: mode 0 gives p=d; mode 1 gives p=~d; mode 2 gives p=all-ones if d>=thresh_in else 0; mode 3 gives p=0.
REQ-019 Stage 2 expands p to CH_W by MSB replication: the output is {p, p[GRAY_W-1 -: CH_W-GRAY_W]}; when CH_W==GRAY_W the output is p unchanged.
REQ-020 vid_out_data is all zeros in any cycle where vid_out_active=0.
REQ-021 A vsync rising edge is the cycle where vid_in_vsync=1 and the registered previous vsync=0.
REQ-022 mode_cur and the captured threshold load mode_in and thresh_in only on a vsync rising-edge cycle, so a frame never changes mode mid-frame.
REQ-023 The mode and threshold loaded on an edge govern the pixels entering from that same cycle onward.
REQ-024 The pixel counter increments on each cycle with vid_in_active=1 and saturates at 2^CNT_W-1 without wrapping.
REQ-025 An active falling edge is the cycle where vid_in_active=0 and the previous active=1.
REQ-026 On an active falling edge: line_len<=counter, line_len_vld=1 for that one cycle, and the counter clears to 0.
REQ-027 A vsync rising edge clears the counter without asserting line_len_vld; if it coincides with an active falling edge, the line_len capture takes priority and the counter still clears.
REQ-028 Mode and threshold changes at times other than a vsync rising edge are ignored.

Reset
REQ-029 While rst=1 at a clk edge: all pipeline registers clear, all vid_out_* are 0, mode_cur=0, captured threshold=0, line_len=0, line_len_vld=0, counter=0, and the previous-vsync/active registers clear to 0.
REQ-030 After rst deasserts, outputs reflect inputs after 2 clk; a vsync already high at deassert counts as a rising edge, because the previous-vsync register is 0.
REQ-031 Asserting reset mid-line discards any partial count and does not produce a line_len_vld strobe.

Verification
REQ-032 Defaults, mode 0: d=8'hA5 with active=1 -> 2 clk later vid_out_data=24'hA5A5A5, active=1.
REQ-033 GRAY_W=8, CH_W=10, NUM_CH=1, mode 0: d=8'hC3 -> vid_out_data=10'b1100001111.
REQ-034 Mode 2 with thresh_in=8'h80 loaded on a vsync edge: d=8'h7F -> 24'h000000; d=8'h80 -> 24'hFFFFFF.
REQ-035 mode_in changes 0->1 mid-frame: output stays in replicate mode until the next vsync rising edge, then d=8'h10 -> 24'hEFEFEF and mode_cur=1.
REQ-036 A 640-cycle active burst followed by active=0 -> line_len=640 with a single-cycle line_len_vld; with CNT_W=8, a 300-pixel line -> line_len=255.
REQ-037 rst pulsed for 1 clk mid-line after 100 active pixels -> all outputs 0 the next cycle, no strobe, and the next full 50-pixel line reports line_len=50.
